// File: rtl/alu_8bit.sv
// Registered 8-bit ALU: sixteen arithmetic, shift, logic and compare operations,
// with the result and carry/status flag registered one cycle after the operands are sampled.
module alu_8bit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [3:0] ctrl,
   output logic [7:0] out,
   output logic       carry
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_MUL  = 4'b0010;
   localparam logic [3:0] OP_DIV  = 4'b0011;
   localparam logic [3:0] OP_SHL  = 4'b0100;
   localparam logic [3:0] OP_SHR  = 4'b0101;
   localparam logic [3:0] OP_ROL  = 4'b0110;
   localparam logic [3:0] OP_ROR  = 4'b0111;
   localparam logic [3:0] OP_AND  = 4'b1000;
   localparam logic [3:0] OP_OR   = 4'b1001;
   localparam logic [3:0] OP_XOR  = 4'b1010;
   localparam logic [3:0] OP_NOR  = 4'b1011;
   localparam logic [3:0] OP_NAND = 4'b1100;
   localparam logic [3:0] OP_XNOR = 4'b1101;
   localparam logic [3:0] OP_GT   = 4'b1110;
   localparam logic [3:0] OP_EQ   = 4'b1111;

   // Shift-and-add array multiplier; 8 partial products summed into a 16-bit product.
   function automatic logic [15:0] mul8(input logic [7:0] x, input logic [7:0] y);
      logic [15:0] acc;
      acc = 16'h0000;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) acc = acc + ({8'h00, x} << i);
      end
      return acc;
   endfunction

   // Restoring array divider, one subtract/compare stage per quotient bit.
   // Caller handles a zero divisor; here it simply yields an all-ones quotient.
   function automatic logic [7:0] div8(input logic [7:0] n, input logic [7:0] d);
      logic [8:0] rem;
      logic [7:0] quo;
      rem = 9'h000;
      quo = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         rem = {rem[7:0], n[i]};
         if (rem >= {1'b0, d}) begin
            rem    = rem - {1'b0, d};
            quo[i] = 1'b1;
         end
      end
      return quo;
   endfunction

   logic [8:0]  sum;
   logic [8:0]  diff;
   logic [15:0] prod;
   logic [7:0]  quot;
   logic [7:0]  res;
   logic        res_c;

   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};
   assign prod = mul8(a, b);
   assign quot = div8(a, b);

   always_comb begin
      // NOTE: defaults first so every path assigns res/res_c and no latch is inferred.
      res   = 8'h00;
      res_c = 1'b0;
      case (ctrl)
         OP_ADD: {res_c, res} = sum;
         OP_SUB: begin
            res   = diff[7:0];
            res_c = diff[8];
         end
         OP_MUL: begin
            res   = prod[7:0];
            res_c = |prod[15:8];
         end
         OP_DIV: begin
            if (b == 8'h00) begin
               res   = 8'hFF;
               res_c = 1'b1;
            end else begin
               res   = quot;
            end
         end
         OP_SHL: begin
            res   = {a[6:0], 1'b0};
            res_c = a[7];
         end
         OP_SHR: begin
            res   = {1'b0, a[7:1]};
            res_c = a[0];
         end
         OP_ROL: begin
            res   = {a[6:0], a[7]};
            res_c = a[7];
         end
         OP_ROR: begin
            res   = {a[0], a[7:1]};
            res_c = a[0];
         end
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         OP_XOR:  res = a ^ b;
         OP_NOR:  res = ~(a | b);
         OP_NAND: res = ~(a & b);
         OP_XNOR: res = ~(a ^ b);
         OP_GT:   res = {7'b0, (a > b)};
         OP_EQ:   res = {7'b0, (a == b)};
         default: begin
            res   = 8'h00;
            res_c = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out   <= 8'h00;
         carry <= 1'b0;
      end else begin
         // NOTE: non-blocking assignment for registered state avoids simulation races.
         out   <= res;
         carry <= res_c;
      end
   end

endmodule

// File: tb/tb_alu_8bit.sv
// Directed testbench for alu_8bit: hand-computed vectors checked one cycle after each is applied.
module tb_alu_8bit;

   logic       clk;
   logic       rst_n;
   logic [7:0] a;
   logic [7:0] b;
   logic [3:0] ctrl;
   logic [7:0] out;
   logic       carry;

   int n_checks = 0;
   int n_fail   = 0;

   alu_8bit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .ctrl  (ctrl),
      .out   (out),
      .carry (carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compares {carry, out} against the expected 9-bit value.
   task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got carry=%b out=%02h, expected carry=%b out=%02h",
                  tag, got[8], got[7:0], exp[8], exp[7:0]);
      end
   endtask

   // Drive operands away from the edge, then check just after the capturing edge.
   task automatic apply(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input logic [3:0] vc, input logic [7:0] eo, input logic ec);
      @(negedge clk);
      a    = va;
      b    = vb;
      ctrl = vc;
      @(posedge clk);
      #1;
      check(tag, {carry, out}, {ec, eo});
   endtask

   initial begin
      rst_n = 1'b0;
      a     = 8'h5A;
      b     = 8'hC3;
      ctrl  = 4'b0000;

      // 1. Reset holds outputs at zero despite clocks and live inputs.
      repeat (3) @(posedge clk);
      #1;
      check("reset_hold", {carry, out}, 9'h000);
      @(negedge clk);
      rst_n = 1'b1;
      apply("add_ff_ff", 8'hFF, 8'hFF, 4'b0000, 8'hFE, 1'b1);

      // 2. Arithmetic sweep, a = b = FF.
      apply("sub_ff", 8'hFF, 8'hFF, 4'b0001, 8'h00, 1'b0);
      apply("mul_ff", 8'hFF, 8'hFF, 4'b0010, 8'h01, 1'b1);
      apply("div_ff", 8'hFF, 8'hFF, 4'b0011, 8'h01, 1'b0);
      apply("shl_ff", 8'hFF, 8'hFF, 4'b0100, 8'hFE, 1'b1);
      apply("shr_ff", 8'hFF, 8'hFF, 4'b0101, 8'h7F, 1'b1);
      apply("rol_ff", 8'hFF, 8'hFF, 4'b0110, 8'hFF, 1'b1);
      apply("ror_ff", 8'hFF, 8'hFF, 4'b0111, 8'hFF, 1'b1);

      // 3. Logic/compare sweep, a = b = FF.
      apply("and_ff",  8'hFF, 8'hFF, 4'b1000, 8'hFF, 1'b0);
      apply("or_ff",   8'hFF, 8'hFF, 4'b1001, 8'hFF, 1'b0);
      apply("xor_ff",  8'hFF, 8'hFF, 4'b1010, 8'h00, 1'b0);
      apply("nor_ff",  8'hFF, 8'hFF, 4'b1011, 8'h00, 1'b0);
      apply("nand_ff", 8'hFF, 8'hFF, 4'b1100, 8'h00, 1'b0);
      apply("xnor_ff", 8'hFF, 8'hFF, 4'b1101, 8'hFF, 1'b0);
      apply("gt_ff",   8'hFF, 8'hFF, 4'b1110, 8'h00, 1'b0);
      apply("eq_ff",   8'hFF, 8'hFF, 4'b1111, 8'h01, 1'b0);

      // 4. Boundaries and mixed patterns.
      apply("sub_borrow", 8'h03, 8'h05, 4'b0001, 8'hFE, 1'b1);
      apply("mul_10_10",  8'h10, 8'h10, 4'b0010, 8'h00, 1'b1);
      apply("mul_0f_10",  8'h0F, 8'h10, 4'b0010, 8'hF0, 1'b0);
      apply("gt_05_03",   8'h05, 8'h03, 4'b1110, 8'h01, 1'b0);
      apply("add_nocarry", 8'h80, 8'h7F, 4'b0000, 8'hFF, 1'b0);
      apply("shl_81",     8'h81, 8'h00, 4'b0100, 8'h02, 1'b1);
      apply("ror_01",     8'h01, 8'h00, 4'b0111, 8'h80, 1'b1);
      apply("rol_80",     8'h80, 8'h00, 4'b0110, 8'h01, 1'b1);
      apply("div_c8_07",  8'hC8, 8'h07, 4'b0011, 8'h1C, 1'b0);
      apply("mul_0d_0b",  8'h0D, 8'h0B, 4'b0010, 8'h8F, 1'b0);
      apply("xor_a5_3c",  8'hA5, 8'h3C, 4'b1010, 8'h99, 1'b0);
      apply("eq_12_13",   8'h12, 8'h13, 4'b1111, 8'h00, 1'b0);
      apply("gt_03_05",   8'h03, 8'h05, 4'b1110, 8'h00, 1'b0);

      // 5. Divide by zero saturates, next cycle divides normally.
      apply("div_by_zero", 8'h2A, 8'h00, 4'b0011, 8'hFF, 1'b1);
      apply("div_2a_05",   8'h2A, 8'h05, 4'b0011, 8'h08, 1'b0);

      // 6. Asynchronous reset between edges clears outputs immediately.
      apply("pre_reset", 8'hFF, 8'hFF, 4'b0000, 8'hFE, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_clear", {carry, out}, 9'h000);
      @(posedge clk);
      #1;
      check("async_hold", {carry, out}, 9'h000);
      @(negedge clk);
      rst_n = 1'b1;
      apply("post_reset_div", 8'h2A, 8'h05, 4'b0011, 8'h08, 1'b0);
      apply("post_reset_sub", 8'h10, 8'h01, 4'b0001, 8'h0F, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
